instruction_fetcher: RTL and testbench

Per-core instruction fetch stage, directly upstream of the core's instruction decoder. When the core scheduler enters FETCH, the block requests the instruction at the current PC from program memory over a valid/ready handshake. It holds the returned 16-bit word on `instruction` for the decoder and reports completion through `fetcher_state`. An optional small direct-mapped instruction cache lets repeated PCs skip the memory round-trip.

---
 rtl/instruction_fetcher.sv | 97 +++++++++
 tb/tb_instruction_fetcher.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: fetch stage issuing one valid/ready program memory read per FETCH.
// Optional direct-mapped instruction cache enabled by INSTRUCTION_FETCHER_CACHE_EN.
module instruction_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_ENTRIES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             cache_invalidate,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);
    localparam int AW = PROGRAM_MEM_ADDR_BITS;
    localparam int DW = PROGRAM_MEM_DATA_BITS;
    localparam logic [2:0] CORE_FETCH = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;
    typedef enum logic [2:0] {IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010} state_t;
    state_t state_q, state_d;
    logic valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] instr_q, instr_d;
    logic hit;
    logic [DW-1:0] hit_data;
    logic fill;
    assign fill = state_q == FETCHING && mem_read_ready;
`ifdef INSTRUCTION_FETCHER_CACHE_EN
    localparam int IW = $clog2(CACHE_ENTRIES);
    logic [AW-IW-1:0] tag_q [CACHE_ENTRIES];
    logic [DW-1:0] data_q [CACHE_ENTRIES];
    logic [CACHE_ENTRIES-1:0] vld_q, vld_d;
    logic [IW-1:0] lk_idx, fill_idx;
    assign lk_idx = current_pc[IW-1:0];
    assign fill_idx = addr_q[IW-1:0];
    assign hit = vld_q[lk_idx] && tag_q[lk_idx] == current_pc[AW-1:IW];
    assign hit_data = data_q[lk_idx];
    // invalidate overrides a same-edge fill so the filled entry stays invalid
    assign vld_d = cache_invalidate ? '0 : fill ? vld_q | (CACHE_ENTRIES'(1) << fill_idx) : vld_q;
    always_ff @(posedge clk) begin
        vld_q <= reset ? '0 : vld_d;
        if (fill) begin
            tag_q[fill_idx] <= addr_q[AW-1:IW];
            data_q[fill_idx] <= mem_read_data;
        end
    end
`else
    localparam int UNUSED_ENTRIES = CACHE_ENTRIES;
    logic unused_inv;
    assign unused_inv = cache_invalidate;
    assign hit = 1'b0;
    assign hit_data = '0;
`endif
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d = addr_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: if (core_state == CORE_FETCH) begin
                state_d = hit ? FETCHED : FETCHING;
                valid_d = !hit;
                addr_d = hit ? addr_q : current_pc;
                instr_d = hit ? hit_data : instr_q;
            end
            FETCHING: if (fill) begin
                state_d = FETCHED;
                valid_d = 1'b0;
                instr_d = mem_read_data;
            end
            FETCHED: if (core_state == CORE_DECODE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q <= addr_d;
            instr_q <= instr_d;
        end
    end
    assign fetcher_state = state_q;
    assign mem_read_valid = valid_q;
    assign mem_read_address = addr_q;
    assign instruction = instr_q;
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: table vectors, directed cache sequences and random traffic
// checked against a transaction-level reference model.
module tb_instruction_fetcher;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int N = 4;
`ifdef INSTRUCTION_FETCHER_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] core_state = '0;
    logic [AW-1:0] current_pc = '0;
    logic cache_invalidate = 1'b0;
    logic mem_read_ready = 1'b0;
    logic [DW-1:0] mem_read_data = '0;
    logic mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic [2:0] fetcher_state;
    logic [DW-1:0] instruction;
    int n_cmp = 0;
    int n_fail = 0;
    int m_st, m_v, m_a, m_i;
    bit c_v [N];
    int c_pc [N];
    int c_d [N];

    always #5 clk = ~clk;

    instruction_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(AW),
        .PROGRAM_MEM_DATA_BITS(DW),
        .CACHE_ENTRIES(N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .core_state(core_state),
        .current_pc(current_pc),
        .cache_invalidate(cache_invalidate),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .fetcher_state(fetcher_state),
        .instruction(instruction)
    );

    typedef struct {
        bit rst;
        int cs, pc;
        bit rdy;
        int rdata;
        bit inv;
        int e_st, e_v, e_a, e_i;
    } vec_t;

    function automatic vec_t mk(int rst, int cs, int pc, int rdy, int rdata, int inv,
                                int e_st, int e_v, int e_a, int e_i);
        vec_t t;
        t.rst = rst != 0;
        t.cs = cs;
        t.pc = pc;
        t.rdy = rdy != 0;
        t.rdata = rdata;
        t.inv = inv != 0;
        t.e_st = e_st;
        t.e_v = e_v;
        t.e_a = e_a;
        t.e_i = e_i;
        return t;
    endfunction

    // Spec-level model: one fetch transaction at a time, cache as pc-keyed slots
    task automatic model_next();
        int k;
        if (reset) begin
            m_st = 0; m_v = 0; m_a = 0; m_i = 0;
            for (int j = 0; j < N; j++) c_v[j] = 1'b0;
            return;
        end
        case (m_st)
            0: if (core_state == 3'd1) begin
                k = int'(current_pc) % N;
                if (CACHE && c_v[k] && c_pc[k] == int'(current_pc)) begin
                    m_i = c_d[k]; m_st = 2;
                end else begin
                    m_a = int'(current_pc); m_v = 1; m_st = 1;
                end
            end
            1: if (mem_read_ready) begin
                m_i = int'(mem_read_data); m_v = 0; m_st = 2;
                k = m_a % N;
                c_v[k] = 1'b1; c_pc[k] = m_a; c_d[k] = m_i;
            end
            default: if (core_state == 3'd2) m_st = 0;
        endcase
        if (cache_invalidate)
            for (int j = 0; j < N; j++) c_v[j] = 1'b0;
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_out(string nm, int st, int v, int a, int i);
        chk({nm, ".state"}, int'(fetcher_state), st);
        chk({nm, ".valid"}, int'(mem_read_valid), v);
        chk({nm, ".addr"}, int'(mem_read_address), a);
        chk({nm, ".instr"}, int'(instruction), i);
    endtask

    task automatic run_vec(vec_t t, string nm);
        reset = t.rst;
        core_state = t.cs[2:0];
        current_pc = t.pc[AW-1:0];
        mem_read_ready = t.rdy;
        mem_read_data = t.rdata[DW-1:0];
        cache_invalidate = t.inv;
        step();
        check_out(nm, t.e_st, t.e_v, t.e_a, t.e_i);
    endtask

    vec_t tbl [20];

    initial begin
        tbl[0]  = mk(1, 0, 'h00, 0, 'h0000, 0, 0, 0, 'h00, 'h0000);
        tbl[1]  = mk(0, 0, 'h05, 0, 'h0000, 0, 0, 0, 'h00, 'h0000);
        tbl[2]  = mk(0, 1, 'h05, 0, 'h0000, 0, 1, 1, 'h05, 'h0000);
        tbl[3]  = mk(0, 1, 'h33, 0, 'h0000, 0, 1, 1, 'h05, 'h0000);
        tbl[4]  = mk(0, 1, 'h05, 0, 'h0000, 0, 1, 1, 'h05, 'h0000);
        tbl[5]  = mk(0, 1, 'h05, 0, 'h0000, 0, 1, 1, 'h05, 'h0000);
        tbl[6]  = mk(0, 1, 'h05, 1, 'h3123, 0, 2, 0, 'h05, 'h3123);
        tbl[7]  = mk(0, 1, 'h05, 1, 'hFFFF, 0, 2, 0, 'h05, 'h3123);
        tbl[8]  = mk(0, 2, 'h05, 0, 'h0000, 0, 0, 0, 'h05, 'h3123);
        tbl[9]  = mk(0, 1, 'h00, 0, 'h0000, 0, 1, 1, 'h00, 'h3123);
        tbl[10] = mk(0, 1, 'h00, 1, 'h9105, 0, 2, 0, 'h00, 'h9105);
        tbl[11] = mk(0, 1, 'h01, 0, 'h0000, 0, 2, 0, 'h00, 'h9105);
        tbl[12] = mk(0, 2, 'h01, 0, 'h0000, 0, 0, 0, 'h00, 'h9105);
        tbl[13] = mk(0, 1, 'h01, 1, 'h1111, 0, 1, 1, 'h01, 'h9105);
        tbl[14] = mk(0, 1, 'h01, 1, 'h3012, 0, 2, 0, 'h01, 'h3012);
        tbl[15] = mk(0, 2, 'h01, 0, 'h0000, 0, 0, 0, 'h01, 'h3012);
        tbl[16] = mk(0, 1, 'h07, 0, 'h0000, 0, 1, 1, 'h07, 'h3012);
        tbl[17] = mk(1, 1, 'h07, 0, 'h0000, 0, 0, 0, 'h00, 'h0000);
        tbl[18] = mk(0, 0, 'h07, 1, 'hFFFF, 0, 0, 0, 'h00, 'h0000);
        tbl[19] = mk(0, 0, 'h07, 1, 'hFFFF, 0, 0, 0, 'h00, 'h0000);
        for (int i = 0; i < 20; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));
`ifdef INSTRUCTION_FETCHER_CACHE_EN
        run_vec(mk(0, 1, 'h04, 0, 'h0000, 0, 1, 1, 'h04, 'h0000), "c_miss04");
        run_vec(mk(0, 1, 'h04, 1, 'h5321, 0, 2, 0, 'h04, 'h5321), "c_fill04");
        run_vec(mk(0, 2, 'h04, 0, 'h0000, 0, 0, 0, 'h04, 'h5321), "c_dec04");
        run_vec(mk(0, 1, 'h09, 0, 'h0000, 0, 1, 1, 'h09, 'h5321), "c_miss09");
        run_vec(mk(0, 1, 'h09, 1, 'h1234, 0, 2, 0, 'h09, 'h1234), "c_fill09");
        run_vec(mk(0, 2, 'h09, 0, 'h0000, 0, 0, 0, 'h09, 'h1234), "c_dec09");
        run_vec(mk(0, 1, 'h04, 0, 'h0000, 0, 2, 0, 'h09, 'h5321), "c_hit04");
        run_vec(mk(0, 2, 'h04, 0, 'h0000, 0, 0, 0, 'h09, 'h5321), "c_dechit");
        run_vec(mk(0, 1, 'h08, 0, 'h0000, 0, 1, 1, 'h08, 'h5321), "c_tagmiss08");
        run_vec(mk(0, 1, 'h08, 1, 'h7777, 0, 2, 0, 'h08, 'h7777), "c_fill08");
        run_vec(mk(0, 2, 'h08, 0, 'h0000, 0, 0, 0, 'h08, 'h7777), "c_dec08");
        run_vec(mk(0, 1, 'h02, 0, 'h0000, 0, 1, 1, 'h02, 'h7777), "c_miss02");
        run_vec(mk(0, 1, 'h02, 1, 'h2222, 1, 2, 0, 'h02, 'h2222), "c_fillinv02");
        run_vec(mk(0, 2, 'h02, 0, 'h0000, 0, 0, 0, 'h02, 'h2222), "c_dec02");
        run_vec(mk(0, 1, 'h02, 0, 'h0000, 0, 1, 1, 'h02, 'h2222), "c_remiss02");
        run_vec(mk(0, 1, 'h02, 1, 'h2223, 0, 2, 0, 'h02, 'h2223), "c_refill02");
        run_vec(mk(0, 2, 'h02, 0, 'h0000, 0, 0, 0, 'h02, 'h2223), "c_redec02");
        run_vec(mk(0, 1, 'h02, 0, 'h0000, 1, 2, 0, 'h02, 'h2223), "c_hitinv02");
        run_vec(mk(0, 2, 'h02, 0, 'h0000, 0, 0, 0, 'h02, 'h2223), "c_dechitinv");
        run_vec(mk(0, 1, 'h02, 0, 'h0000, 0, 1, 1, 'h02, 'h2223), "c_postinv02");
        run_vec(mk(0, 1, 'h02, 1, 'h4444, 0, 2, 0, 'h02, 'h4444), "c_postfill02");
        run_vec(mk(0, 2, 'h02, 0, 'h0000, 0, 0, 0, 'h02, 'h4444), "c_postdec02");
`else
        run_vec(mk(0, 1, 'h05, 0, 'h0000, 1, 1, 1, 'h05, 'h0000), "n_miss05");
        run_vec(mk(0, 1, 'h05, 1, 'h3123, 1, 2, 0, 'h05, 'h3123), "n_fill05");
        run_vec(mk(0, 2, 'h05, 0, 'h0000, 0, 0, 0, 'h05, 'h3123), "n_dec05");
        run_vec(mk(0, 1, 'h05, 0, 'h0000, 0, 1, 1, 'h05, 'h3123), "n_refetch05");
        run_vec(mk(0, 1, 'h05, 1, 'hABCD, 0, 2, 0, 'h05, 'hABCD), "n_refill05");
        run_vec(mk(0, 2, 'h05, 0, 'h0000, 0, 0, 0, 'h05, 'hABCD), "n_redec05");
`endif
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 9);
            reset = $urandom_range(0, 63) == 0;
            core_state = r < 5 ? 3'd1 : r < 8 ? 3'd2 : 3'($urandom_range(0, 7));
            current_pc = 8'($urandom_range(0, 15));
            mem_read_ready = $urandom_range(0, 1) == 1;
            mem_read_data = 16'($urandom);
            cache_invalidate = $urandom_range(0, 15) == 0;
            step();
            check_out("rand", m_st, m_v, m_a, m_i);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
